// File: rtl/dmi_dtm_pkg.sv
// Shared types for the JTAG DTM controller: DMI op/error encodings, DTMCS layout
// and DMI request/response bundles.
package dmi_dtm_pkg;

    localparam logic [3:0] DTM_VERSION = 4'd1;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RSVD  = 2'd3
    } dtm_op_e;

    typedef enum logic [1:0] {
        OK     = 2'd0,
        FAILED = 2'd2,
        BUSY   = 2'd3
    } dtm_err_e;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        dtm_err_e    dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    // Address is width-parameterised in the controller, so it is kept outside these bundles.
    typedef struct packed {
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [1:0]  err;
        logic [31:0] data;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_dtm_ctrl.sv
// DTM controller: DTMCS/DMI data registers, single-outstanding DMI request sequencer
// and sticky busy/failed error tracking, all in the TCK domain.
module dmi_dtm_ctrl
    import dmi_dtm_pkg::*;
#(
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned IdleHint  = 1
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 dmi_clear_i,
    input  logic                 capture_i,
    input  logic                 shift_i,
    input  logic                 update_i,
    input  logic                 tdi_i,
    input  logic                 dtmcs_select_i,
    input  logic                 dmi_select_i,
    output logic                 dtmcs_tdo_o,
    output logic                 dmi_tdo_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [31:0]          dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_err_i,
    output logic                 dmi_hardreset_o
);

    localparam int unsigned DRW = AddrWidth + 34;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_WAIT_R,
        ST_WAIT_W
    } state_e;

    state_e                 state_q, state_d;
    dtm_err_e               error_q, error_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [31:0]            data_q, data_d;
    logic [31:0]            dtmcs_sr, dtmcs_sr_d;
    logic [DRW-1:0]         dmi_sr, dmi_sr_d;
    logic                   hardreset_q;

    dtmcs_t                 dtmcs_val;
    dmi_req_t               req;
    dmi_resp_t              resp;
    dtm_op_e                sr_op;
    logic                   busy_now;
    logic                   clear;
    logic [1:0]             cap_op;

    always_comb begin
        dtmcs_val              = '0;
        dtmcs_val.idle         = 3'(IdleHint);
        dtmcs_val.dmistat      = error_q;
        dtmcs_val.abits        = 6'(AddrWidth);
        dtmcs_val.version      = DTM_VERSION;
    end

    assign resp     = '{err: dmi_resp_err_i, data: dmi_resp_data_i};
    assign sr_op    = dtm_op_e'(dmi_sr[1:0]);
    assign busy_now = (state_q != ST_IDLE) && (error_q == OK);
    assign cap_op   = busy_now ? 2'(BUSY) : 2'(error_q);
    // Bit 17 of the shifted DTMCS value is dmihardreset, bit 16 is dmireset.
    assign clear    = dmi_clear_i | (update_i & dtmcs_select_i & dtmcs_sr[17]);

    always_comb begin
        state_d    = state_q;
        error_d    = error_q;
        addr_d     = addr_q;
        data_d     = data_q;
        dtmcs_sr_d = dtmcs_sr;
        dmi_sr_d   = dmi_sr;

        unique case (state_q)
            ST_READ:  if (dmi_req_ready_i) state_d = ST_WAIT_R;
            ST_WRITE: if (dmi_req_ready_i) state_d = ST_WAIT_W;
            ST_WAIT_R, ST_WAIT_W: begin
                if (dmi_resp_valid_i) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_WAIT_R) data_d = resp.data;
                    if (resp.err != 2'b00 && error_q == OK) error_d = FAILED;
                end
            end
            default: ;
        endcase

        // Busy is applied after the response so a same-cycle busy is never lost.
        if (capture_i && dmi_select_i) begin
            if (busy_now) error_d = BUSY;
            dmi_sr_d = {addr_q, data_q, cap_op};
        end else if (shift_i && dmi_select_i) begin
            dmi_sr_d = {tdi_i, dmi_sr[DRW-1:1]};
        end

        if (update_i && dmi_select_i && error_q == OK) begin
            if (state_q != ST_IDLE) begin
                error_d = BUSY;
            end else begin
                addr_d = dmi_sr[DRW-1:34];
                case (sr_op)
                    READ:  state_d = ST_READ;
                    WRITE: begin
                        data_d  = dmi_sr[33:2];
                        state_d = ST_WRITE;
                    end
                    default: ;
                endcase
            end
        end

        if (capture_i && dtmcs_select_i) begin
            dtmcs_sr_d = dtmcs_val;
        end else if (shift_i && dtmcs_select_i) begin
            dtmcs_sr_d = {tdi_i, dtmcs_sr[31:1]};
        end

        if (update_i && dtmcs_select_i && dtmcs_sr[16]) error_d = OK;

        if (clear) begin
            state_d = ST_IDLE;
            error_d = OK;
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q     <= ST_IDLE;
            error_q     <= OK;
            addr_q      <= '0;
            data_q      <= '0;
            dtmcs_sr    <= '0;
            dmi_sr      <= '0;
            hardreset_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            error_q     <= error_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            dtmcs_sr    <= dtmcs_sr_d;
            dmi_sr      <= dmi_sr_d;
            hardreset_q <= clear;
        end
    end

    always_comb begin
        req.data = data_q;
        unique case (state_q)
            ST_READ:  req.op = READ;
            ST_WRITE: req.op = WRITE;
            default:  req.op = NOP;
        endcase
    end

    assign dmi_req_valid_o  = (state_q == ST_READ) || (state_q == ST_WRITE);
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = req.data;
    assign dmi_req_op_o     = req.op;
    assign dmi_resp_ready_o = (state_q == ST_WAIT_R) || (state_q == ST_WAIT_W);
    assign dtmcs_tdo_o      = dtmcs_sr[0];
    assign dmi_tdo_o        = dmi_sr[0];
    assign dmi_hardreset_o  = hardreset_q;

endmodule

// File: tb/tb_dmi_dtm_ctrl.sv
// Directed bench for dmi_dtm_ctrl: TAP-style DR scans against a hand-driven Debug Module.
module tb_dmi_dtm_ctrl;

    logic        tck = 1'b0;
    logic        trst_n;
    logic        dmi_clear, capture, shift, update, tdi;
    logic        dtmcs_select, dmi_select;
    logic        dtmcs_tdo, dmi_tdo;
    logic        req_valid, req_ready;
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_op;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;
    logic        hardreset;

    int n_cmp = 0;
    int n_err = 0;

    logic [40:0] dmi_out;
    logic [31:0] dtmcs_out;

    dmi_dtm_ctrl #(.AddrWidth(7), .IdleHint(1)) dut (
        .tck_i            (tck),
        .trst_ni          (trst_n),
        .dmi_clear_i      (dmi_clear),
        .capture_i        (capture),
        .shift_i          (shift),
        .update_i         (update),
        .tdi_i            (tdi),
        .dtmcs_select_i   (dtmcs_select),
        .dmi_select_i     (dmi_select),
        .dtmcs_tdo_o      (dtmcs_tdo),
        .dmi_tdo_o        (dmi_tdo),
        .dmi_req_valid_o  (req_valid),
        .dmi_req_ready_i  (req_ready),
        .dmi_req_addr_o   (req_addr),
        .dmi_req_data_o   (req_data),
        .dmi_req_op_o     (req_op),
        .dmi_resp_valid_i (resp_valid),
        .dmi_resp_ready_o (resp_ready),
        .dmi_resp_data_i  (resp_data),
        .dmi_resp_err_i   (resp_err),
        .dmi_hardreset_o  (hardreset)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture, shift n bits (LSB first), update; returns at the negedge after the update edge.
    task automatic scan(input logic sel_dmi, input logic [40:0] din, input int n,
                        output logic [40:0] dout);
        dout = '0;
        dmi_select   = sel_dmi;
        dtmcs_select = ~sel_dmi;
        capture      = 1'b1;
        @(negedge tck);
        capture = 1'b0;
        shift   = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdi     = din[i];
            dout[i] = sel_dmi ? dmi_tdo : dtmcs_tdo;
            @(negedge tck);
        end
        shift  = 1'b0;
        update = 1'b1;
        @(negedge tck);
        update       = 1'b0;
        dmi_select   = 1'b0;
        dtmcs_select = 1'b0;
    endtask

    task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                            output logic [40:0] dout);
        scan(1'b1, {a, d, op}, 41, dout);
    endtask

    task automatic dtmcs_scan(input logic [31:0] din, output logic [31:0] dout);
        logic [40:0] tmp;
        scan(1'b0, {9'd0, din}, 32, tmp);
        dout = tmp[31:0];
    endtask

    task automatic accept_req;
        req_ready = 1'b1;
        @(negedge tck);
        req_ready = 1'b0;
    endtask

    task automatic give_resp(input logic [31:0] d, input logic [1:0] e);
        resp_valid = 1'b1;
        resp_data  = d;
        resp_err   = e;
        @(negedge tck);
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = '0;
    endtask

    initial begin
        trst_n = 1'b0;
        {dmi_clear, capture, shift, update, tdi, dtmcs_select, dmi_select} = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; resp_err = '0;
        #1;
        check("rst_outputs", {req_valid, resp_ready, hardreset, dtmcs_tdo, dmi_tdo, req_op}, 0);
        check("rst_addr_data", {req_addr, req_data}, 0);
        repeat (2) @(negedge tck);
        trst_n = 1'b1;
        @(negedge tck);

        // DTMCS identification after reset
        dtmcs_scan(32'h0, dtmcs_out);
        check("dtmcs_reset", dtmcs_out, 32'h0000_1071);

        // Write 0xDEADBEEF to 0x10, ready next cycle, ok response
        dmi_scan(7'h10, 32'hDEADBEEF, 2'd2, dmi_out);
        check("wr_req", {req_valid, req_op, req_addr, req_data, resp_ready},
              {1'b1, 2'd2, 7'h10, 32'hDEADBEEF, 1'b0});
        accept_req();
        check("wr_wait", {req_valid, resp_ready}, 2'b01);
        give_resp(32'h0, 2'd0);
        check("wr_done", {req_valid, resp_ready}, 2'b00);
        dtmcs_scan(32'h0, dtmcs_out);
        check("wr_dmistat", dtmcs_out, 32'h0000_1071);

        // Read 0x04 returning 0x12345678; next capture shows data with op=0
        dmi_scan(7'h04, 32'h0, 2'd1, dmi_out);
        check("rd_req", {req_valid, req_op, req_addr}, {1'b1, 2'd1, 7'h04});
        accept_req();
        give_resp(32'h12345678, 2'd0);
        dmi_scan(7'h00, 32'h0, 2'd0, dmi_out);
        check("rd_capture", dmi_out, {7'h04, 32'h12345678, 2'd0});

        // Read 0x08 left pending; capture during WAIT_R reports busy
        dmi_scan(7'h08, 32'h0, 2'd1, dmi_out);
        accept_req();
        dmi_scan(7'h20, 32'hCAFEF00D, 2'd2, dmi_out);
        check("busy_capture", dmi_out, {7'h08, 32'h12345678, 2'd3});
        check("busy_upd_ignored", {req_valid, resp_ready}, 2'b01);
        repeat (5) @(negedge tck);
        give_resp(32'hA5A5A5A5, 2'd0);
        dtmcs_scan(32'h0, dtmcs_out);
        check("busy_dmistat", dtmcs_out, 32'h0000_1C71);
        dmi_scan(7'h30, 32'h1, 2'd2, dmi_out);
        check("sticky_capture", dmi_out[1:0], 2'd3);
        check("sticky_upd_ignored", req_valid, 1'b0);
        dtmcs_scan(32'h0001_0000, dtmcs_out);
        check("dmireset_capture", dtmcs_out, 32'h0000_1C71);
        dmi_scan(7'h00, 32'h0, 2'd0, dmi_out);
        check("after_dmireset", dmi_out, {7'h08, 32'hA5A5A5A5, 2'd0});

        // Read 0x05 with delayed ready and failing response
        dmi_scan(7'h05, 32'h0, 2'd1, dmi_out);
        repeat (2) @(negedge tck);
        check("rd_hold", {req_valid, req_op, req_addr}, {1'b1, 2'd1, 7'h05});
        accept_req();
        give_resp(32'hFFFF0000, 2'd2);
        dtmcs_scan(32'h0001_0000, dtmcs_out);
        check("failed_dmistat", dtmcs_out, 32'h0000_1871);
        dtmcs_scan(32'h0, dtmcs_out);
        check("failed_cleared", dtmcs_out, 32'h0000_1071);
        dmi_scan(7'h00, 32'h0, 2'd0, dmi_out);
        check("failed_rd_data", dmi_out, {7'h05, 32'hFFFF0000, 2'd0});

        // dmihardreset during WAIT_W
        dmi_scan(7'h11, 32'h0BADF00D, 2'd2, dmi_out);
        accept_req();
        check("hr_wait_w", resp_ready, 1'b1);
        dtmcs_scan(32'h0002_0000, dtmcs_out);
        check("hr_pulse", {hardreset, resp_ready, req_valid}, 3'b100);
        @(negedge tck);
        check("hr_pulse_end", hardreset, 1'b0);

        // dmi_clear during WAIT_R
        dmi_scan(7'h06, 32'h0, 2'd1, dmi_out);
        accept_req();
        dmi_clear = 1'b1;
        @(negedge tck);
        dmi_clear = 1'b0;
        check("clr_pulse", {hardreset, resp_ready}, 2'b10);
        @(negedge tck);
        check("clr_pulse_end", hardreset, 1'b0);

        // Asynchronous trst_ni with a request outstanding
        dmi_scan(7'h07, 32'h0, 2'd1, dmi_out);
        check("trst_pre", req_valid, 1'b1);
        trst_n = 1'b0;
        #1;
        check("trst_async", {req_valid, req_op, req_addr, req_data}, 0);
        @(negedge tck);
        trst_n = 1'b1;
        @(negedge tck);
        dtmcs_scan(32'h0, dtmcs_out);
        check("trst_dtmcs", dtmcs_out, 32'h0000_1071);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
